// File: rtl/thumb_fetch_pkg.sv
// Shared types and constants for the Thumb instruction fetch unit.
package thumb_fetch_pkg;

    typedef enum logic [1:0] {
        REQ       = 2'd0,
        WAIT      = 2'd1,
        WAIT_DROP = 2'd2
    } fetch_state_t;

    localparam int FETCH_FIFO_DEPTH = 4;
    localparam int HALFWORD_W       = 16;
    localparam int WORD_BYTES       = 4;

endpackage

// File: rtl/thumb_fetch_if.sv
// Bundle of the instruction-memory bus, the decode-side halfword handshake
// and the branch redirect inputs. The fetch unit is the master side.
interface thumb_fetch_if
    import thumb_fetch_pkg::*;
    #(parameter int ADDR_W = 32);

    logic                  mem_req;
    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_valid;
    logic [31:0]           mem_rdata;
    logic [HALFWORD_W-1:0] instruction;
    logic [ADDR_W-1:0]     instr_pc;
    logic                  instr_valid;
    logic                  instr_ready;
    logic                  redirect;
    logic [ADDR_W-1:0]     redirect_pc;

    modport master (
        output mem_req, mem_addr, instruction, instr_pc, instr_valid,
        input  mem_valid, mem_rdata, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  mem_req, mem_addr, instruction, instr_pc, instr_valid,
        output mem_valid, mem_rdata, instr_ready, redirect, redirect_pc
    );

endinterface

// File: rtl/thumb_fetch_hw_fifo.sv
// Four-entry halfword circular buffer: accepts 0, 1 or 2 halfwords per
// cycle, releases at most one, and can be emptied in a single cycle.
module hw_fifo
    import thumb_fetch_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [1:0]            push_cnt,
    input  logic [HALFWORD_W-1:0] push_lo,
    input  logic [HALFWORD_W-1:0] push_hi,
    input  logic                  pop,
    output logic [HALFWORD_W-1:0] head,
    output logic [2:0]            count
);

    logic [HALFWORD_W-1:0] mem [FETCH_FIFO_DEPTH];
    logic [1:0]            rd_ptr;
    logic [1:0]            wr_ptr;

    // Storage, pointers and occupancy; flush empties without touching data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FETCH_FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_cnt != 2'd0) begin
                mem[wr_ptr] <= push_lo;
            end
            if (push_cnt == 2'd2) begin
                mem[wr_ptr + 2'd1] <= push_hi;
            end
            wr_ptr <= wr_ptr + push_cnt;
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            count <= count + {1'b0, push_cnt} - {2'b00, pop};
        end
    end

    assign head = mem[rd_ptr];

    // The fetch issue rule must never let the buffer exceed its depth.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !flush |-> ({1'b0, count} + {2'b00, push_cnt} - {3'b000, pop}) <= 4'(FETCH_FIFO_DEPTH));

endmodule

// File: rtl/thumb_fetch.sv
// Thumb instruction fetch: requests little-endian words from instruction
// memory, splits them into halfwords and streams them to decode, honouring
// branch redirects (including halfword-aligned targets and stale responses).
module thumb_fetch
    import thumb_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
)(
    input  logic          clk,
    input  logic          rst,
    thumb_fetch_if.master bus
);

    localparam logic [1:0] ST_REQ       = REQ;
    localparam logic [1:0] ST_WAIT      = WAIT;
    localparam logic [1:0] ST_WAIT_DROP = WAIT_DROP;

    localparam logic [ADDR_W-1:0] WORD_MASK   = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] HW_MASK     = ~ADDR_W'(1);
    localparam logic [ADDR_W-1:0] RESET_FETCH = RESET_PC & WORD_MASK;
    localparam logic [ADDR_W-1:0] RESET_INSTR = RESET_PC & HW_MASK;

    logic [1:0]            state;
    logic [ADDR_W-1:0]     fetch_pc;
    logic [ADDR_W-1:0]     instr_pc;
    logic                  skip_low;
    logic [2:0]            count;
    logic                  issue;
    logic                  accept;
    logic                  pop;
    logic [1:0]            push_cnt;
    logic [HALFWORD_W-1:0] push_lo;
    logic [HALFWORD_W-1:0] push_hi;
    logic [HALFWORD_W-1:0] head;

    // Issue, accept and pop decisions; a redirect overrides all of them.
    always_comb begin
        issue    = !rst && (state == ST_REQ) && (count <= 3'd2) && !bus.redirect;
        accept   = (state == ST_WAIT) && bus.mem_valid && !bus.redirect;
        pop      = (count != 3'd0) && bus.instr_ready && !bus.redirect;
        push_cnt = 2'd0;
        if (accept) begin
            push_cnt = skip_low ? 2'd1 : 2'd2;
        end
        push_lo  = skip_low ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        push_hi  = bus.mem_rdata[31:16];
    end

    hw_fifo u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (bus.redirect),
        .push_cnt (push_cnt),
        .push_lo  (push_lo),
        .push_hi  (push_hi),
        .pop      (pop),
        .head     (head),
        .count    (count)
    );

    // Request sequencing with one outstanding word; stale responses are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_REQ;
        end else begin
            case (state)
                ST_REQ: begin
                    if (issue) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.redirect && !bus.mem_valid) begin
                        state <= ST_WAIT_DROP;
                    end else if (bus.mem_valid) begin
                        state <= ST_REQ;
                    end
                end
                ST_WAIT_DROP: begin
                    if (bus.mem_valid) begin
                        state <= ST_REQ;
                    end
                end
                default: state <= ST_REQ;
            endcase
        end
    end

    // Fetch address, decode address and the half-word skip for odd targets.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_FETCH;
            instr_pc <= RESET_INSTR;
            skip_low <= RESET_PC[1];
        end else if (bus.redirect) begin
            fetch_pc <= bus.redirect_pc & WORD_MASK;
            instr_pc <= bus.redirect_pc & HW_MASK;
            skip_low <= bus.redirect_pc[1];
        end else begin
            if (accept) begin
                fetch_pc <= fetch_pc + ADDR_W'(WORD_BYTES);
                skip_low <= 1'b0;
            end
            if (pop) begin
                instr_pc <= instr_pc + ADDR_W'(2);
            end
        end
    end

    assign bus.mem_req     = issue;
    assign bus.mem_addr    = fetch_pc;
    assign bus.instr_valid = (count != 3'd0);
    assign bus.instruction = head;
    assign bus.instr_pc    = instr_pc;

    // Memory only answers requests, so a response while idle is a bus error.
    a_no_unsolicited: assert property (@(posedge clk) disable iff (rst)
        bus.mem_valid |-> (state != ST_REQ));

endmodule
